// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmitter: frame width, default clocking
// and the transmit FSM state type.
package uart_tx_pkg;

    localparam int unsigned UART_DATA_BITS    = 8;
    localparam int unsigned UART_DEF_CLK_FREQ = 12000000;
    localparam int unsigned UART_DEF_BAUD     = 115200;

    typedef enum logic [1:0] {
        UART_TX_IDLE  = 2'd0,
        UART_TX_START = 2'd1,
        UART_TX_DATA  = 2'd2,
        UART_TX_STOP  = 2'd3
    } uart_tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO for the UART transmitter. Pointers carry one extra
// wrap bit so full and empty fall out of a plain pointer compare. The head
// entry is read combinationally so a pop and its load share one cycle.
module uart_tx_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             wr,
    input  logic             rd,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_en;
    logic             rd_en;

    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty = (wptr == rptr);
    assign wr_en = wr & ~full;
    assign rd_en = rd & ~empty;
    assign dout  = mem[rptr[AW-1:0]];

    // Advance the pointers on accepted writes and pops; reset flushes the FIFO.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_en) wptr <= wptr + 1'b1;
            if (rd_en) rptr <= rptr + 1'b1;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk_i) begin
        if (wr_en) mem[wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_tx.sv
// Byte-oriented 8N1 UART transmitter with an internal byte FIFO. The system
// clock is divided down to the bit rate internally; frames are sent back to
// back while the FIFO holds data.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = UART_DEF_CLK_FREQ,
    parameter int unsigned BAUD       = UART_DEF_BAUD,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic [UART_DATA_BITS-1:0] data_i,
    input  logic                      data_i_v,
    output logic                      ready_o,
    output logic                      tx_o,
    output logic                      busy_o,
    output logic                      overflow_o
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned BW           = $clog2(CLKS_PER_BIT);

    uart_tx_state_e            state;
    logic [BW-1:0]             baud_cnt;
    logic [2:0]                bit_cnt;
    logic [UART_DATA_BITS-1:0] shift_q;
    logic [UART_DATA_BITS-1:0] fifo_dout;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      baud_end;
    logic                      pop;

    assign baud_end = (baud_cnt == BW'(CLKS_PER_BIT - 1));
    // The FSM loads the head in IDLE, or at the end of a stop bit so that
    // queued frames follow each other with no idle gap.
    assign pop      = ~fifo_empty &
                      ((state == UART_TX_IDLE) | ((state == UART_TX_STOP) & baud_end));
    assign ready_o  = ~fifo_full;
    assign busy_o   = (state != UART_TX_IDLE) | ~fifo_empty;

    uart_tx_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .wr     (data_i_v & ~fifo_full),
        .rd     (pop),
        .din    (data_i),
        .dout   (fifo_dout),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // Sticky overflow flag: any write attempt while full, even alongside a pop.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            overflow_o <= 1'b0;
        end else if (data_i_v & fifo_full) begin
            overflow_o <= 1'b1;
        end
    end

    // Transmit FSM: start bit, eight data bits LSB first, stop bit.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state    <= UART_TX_IDLE;
            tx_o     <= 1'b1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift_q  <= '0;
        end else begin
            case (state)
                UART_TX_IDLE: begin
                    tx_o <= 1'b1;
                    if (pop) begin
                        shift_q  <= fifo_dout;
                        tx_o     <= 1'b0;
                        baud_cnt <= '0;
                        state    <= UART_TX_START;
                    end
                end
                UART_TX_START: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        tx_o     <= shift_q[0];
                        bit_cnt  <= '0;
                        state    <= UART_TX_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                UART_TX_DATA: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        shift_q  <= shift_q >> 1;
                        if (bit_cnt == 3'(UART_DATA_BITS - 1)) begin
                            tx_o  <= 1'b1;
                            state <= UART_TX_STOP;
                        end else begin
                            tx_o    <= shift_q[1];
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                UART_TX_STOP: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (pop) begin
                            shift_q <= fifo_dout;
                            tx_o    <= 1'b0;
                            state   <= UART_TX_START;
                        end else begin
                            state   <= UART_TX_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a frame-level line model compared every
// cycle, literal timing checks, and a mid-bit sampling receiver.
module tb_uart_tx;

    localparam int CPB   = 12000000 / 115200;
    localparam int FRAME = 10 * CPB;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [7:0] data = '0;
    logic       v = 1'b0;
    logic       ready_o, tx_o, busy_o, overflow_o;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // line model: queued bytes, frame in flight and its cycle position
    logic [7:0] m_q [$];
    bit         m_active = 0;
    int         m_fc = 0;
    logic [7:0] m_cur = '0;
    bit         m_ovf = 0;

    bit         dec_en = 0;
    logic [7:0] rx_q [$];

    uart_tx #(.CLK_FREQ(12000000), .BAUD(115200), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i(clk), .rstn_i(rstn), .data_i(data), .data_i_v(v),
        .ready_o(ready_o), .tx_o(tx_o), .busy_o(busy_o), .overflow_o(overflow_o)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit exp_tx();
        int idx;
        if (!m_active) return 1'b1;
        idx = m_fc / CPB;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return m_cur[idx-1];
        return 1'b1;
    endfunction

    // one clock edge of the model, using the inputs the DUT will sample next
    task automatic model_step();
        bit pop;
        bit wr_ok;
        int sz;
        sz    = m_q.size();
        pop   = (sz > 0) && (!m_active || m_fc == FRAME - 1);
        wr_ok = v && (sz < DEPTH);
        if (v && sz == DEPTH) m_ovf = 1;
        if (m_active) begin
            if (m_fc == FRAME - 1) begin
                if (pop) begin m_cur = m_q.pop_front(); m_fc = 0; end
                else m_active = 0;
            end else begin
                m_fc++;
            end
        end else if (pop) begin
            m_cur = m_q.pop_front(); m_fc = 0; m_active = 1;
        end
        if (wr_ok) m_q.push_back(data);
    endtask

    // compare process: every cycle, away from the active edge
    initial forever begin
        @(negedge clk);
        if (!rstn) begin
            m_q.delete(); m_active = 0; m_fc = 0; m_ovf = 0;
        end
        check("tx_o",       tx_o,       exp_tx());
        check("busy_o",     busy_o,     (m_active || m_q.size() > 0));
        check("ready_o",    ready_o,    (m_q.size() < DEPTH));
        check("overflow_o", overflow_o, m_ovf);
        if (rstn) model_step();
    end

    // mid-bit sampling receiver
    initial begin
        logic prev;
        logic [7:0] b;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (dec_en && prev && !tx_o) begin
                repeat (CPB / 2) @(negedge clk);
                check("rx_start", tx_o, 0);
                b = '0;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx_o;
                end
                repeat (CPB) @(negedge clk);
                check("rx_stop", tx_o, 1);
                rx_q.push_back(b);
            end
            prev = tx_o;
        end
    end

    task automatic wr(input logic [7:0] b);
        @(posedge clk); #1;
        v = 1'b1; data = b;
    endtask

    task automatic wr_end();
        @(posedge clk); #1;
        v = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rstn = 1'b0;
        @(posedge clk); #1 rstn = 1'b1;
    endtask

    task automatic wait_idle(input int lim);
        int n;
        n = 0;
        while (busy_o && n < lim) begin
            @(posedge clk); #1;
            n++;
        end
        check("idle_timeout", busy_o, 0);
    endtask

    initial begin
        logic [9:0] a5_line;
        int n;
        a5_line = 10'b1_1010_0101_0;  // stop, A5 MSB..LSB, start

        // reset values
        step(3);
        check("rst_tx", tx_o, 1);
        check("rst_ready", ready_o, 1);
        check("rst_busy", busy_o, 0);
        check("rst_ovf", overflow_o, 0);
        rstn = 1'b1;
        step(5);

        // single 0xA5: written at edge N
        wr(8'hA5);
        wr_end();                       // now just after N
        check("a5_tx_n", tx_o, 1);
        step(1);                        // N+1
        check("a5_tx_n1", tx_o, 0);
        step(CPB / 2);                  // N+53
        for (int k = 0; k < 10; k++) begin
            check("a5_bit", tx_o, a5_line[k]);
            if (k < 9) step(CPB);
        end
        step(FRAME - CPB / 2 - 9 * CPB - 1);   // N+1040
        check("a5_busy_1040", busy_o, 1);
        step(1);                        // N+1041
        check("a5_busy_1041", busy_o, 0);
        check("a5_tx_idle", tx_o, 1);

        // three back-to-back frames, written at E, E+1, E+2
        step(7);
        wr(8'h00); wr(8'hFF); wr(8'h55);
        wr_end();                       // just after E+2
        step(3 * FRAME - 2);            // E+3120
        check("b2b_busy_3120", busy_o, 1);
        step(1);
        check("b2b_busy_3121", busy_o, 0);

        // 17 writes fill 1 in flight + 16 queued; 18th is dropped
        do_reset();
        rx_q.delete();
        dec_en = 1;
        for (int i = 0; i <= 16; i++) wr(8'(i));
        wr_end();
        check("fill_ready", ready_o, 0);
        check("fill_ovf", overflow_o, 0);
        wr(8'h11);
        wr_end();
        check("ovf_set", overflow_o, 1);
        check("ovf_ready", ready_o, 0);
        wait_idle(20 * FRAME);
        check("ovf_sticky", overflow_o, 1);
        dec_en = 0;
        check("rx_count", rx_q.size(), 17);
        for (int i = 0; i < 17 && i < rx_q.size(); i++) check("rx_byte", rx_q[i], i);

        // write while full on the same edge the FSM pops
        do_reset();
        for (int i = 0; i <= 16; i++) wr(8'(8'h40 + i));
        wr_end();
        check("pf_ready", ready_o, 0);
        n = 0;
        while (!(m_active && m_fc == FRAME - 1) && n < 2 * FRAME) begin
            @(posedge clk); #1;
            n++;
        end
        check("pf_found", (n < 2 * FRAME), 1);
        v = 1'b1; data = 8'h77;
        wr_end();
        check("pf_ovf", overflow_o, 1);
        check("pf_ready_after", ready_o, 1);
        wr(8'h78);                      // count was DEPTH-1: this one fits
        wr_end();
        check("pf_refull", ready_o, 0);

        // async reset mid-DATA with 3 bytes queued
        do_reset();
        wr(8'h3C); wr(8'hC3); wr(8'h0F); wr(8'hF0);
        wr_end();
        step(300);
        check("mid_busy", busy_o, 1);
        @(posedge clk); #1 rstn = 1'b0;
        #1;
        check("ar_tx", tx_o, 1);
        check("ar_busy", busy_o, 0);
        check("ar_ready", ready_o, 1);
        check("ar_ovf", overflow_o, 0);
        step(3);
        rstn = 1'b1;
        step(2 * FRAME);
        check("post_tx", tx_o, 1);
        check("post_busy", busy_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Byte-oriented UART transmitter, 8N1 framing, with an internal byte FIFO; the transmit-side counterpart of the existing uart_rx.
- Sits beside uart_rx under top and sends debug/status bytes from the interpreter back to the host over RS232.
- Runs from a single system clock and divides that clock internally to the baud rate, so it needs no dedicated clks instance.

Parameters:
- CLK_FREQ, 12000000, clk_i frequency in Hz.
- BAUD, 115200, line rate in bits/s. CLKS_PER_BIT = CLK_FREQ / BAUD, truncated (104 at the defaults); must be >= 2.
- FIFO_DEPTH, 16, byte FIFO depth; must be a power of 2 and >= 2.

Ports:
- clk_i  input  1  system clock.
- rstn_i  input  1  asynchronous active-low reset.
- data_i  input  8  byte to transmit.
- data_i_v  input  1  write strobe; data_i is pushed on any clk_i edge where data_i_v=1 and ready_o=1.
- ready_o  output  1  FIFO not full.
- tx_o  output  1  serial line; idles high.
- busy_o  output  1  high when the FIFO is non-empty or a frame is in progress.
- overflow_o  output  1  sticky; set when a write is attempted while full; cleared only by reset.

Behaviour:
- Reset (async, rstn_i=0):
  - tx_o=1, ready_o=1, busy_o=0, overflow_o=0.
  - FIFO flushed (pointers and count = 0); FSM in IDLE; baud and bit counters cleared.
  - A reset mid-frame aborts the frame immediately; tx_o returns high with no glitch low.
- All outputs are registered except ready_o (= ~full) and busy_o (= (state != IDLE) | ~empty), which are decoded from registers.
- FIFO:
  - Write when data_i_v & ~full.
  - data_i_v & full: data is dropped, pointers are unchanged, overflow_o <= 1.
  - A pop in the same cycle does NOT make room for a write while full.
  - Pointers are log2(FIFO_DEPTH)+1 bits; full/empty are detected from the MSB difference; wrap-around is natural.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx_o=1. If FIFO non-empty: pop the head into an 8-bit shift register, tx_o <= 0, baud_cnt <= 0, go to START.
  - START: hold tx_o=0 for CLKS_PER_BIT cycles. Then tx_o <= shift[0], bit_cnt <= 0, go to DATA.
  - DATA: each bit is held CLKS_PER_BIT cycles, LSB first. At the end of each bit: shift right, bit_cnt++. After bit 7: tx_o <= 1, go to STOP.
  - STOP: tx_o=1 for CLKS_PER_BIT cycles. At the end:
    - FIFO non-empty: pop, tx_o <= 0, go directly to START (back-to-back frames, no idle gap).
    - Otherwise: go to IDLE.
- Timing:
  - A write into an empty FIFO with the FSM in IDLE at edge N makes tx_o fall after edge N+1.
  - A frame is exactly 10*CLKS_PER_BIT cycles (1040 at the defaults).
- baud_cnt counts 0..CLKS_PER_BIT-1 and wraps at each bit boundary. Its width is $clog2(CLKS_PER_BIT).
- Simultaneous write and pop on a non-full FIFO: both take effect; count is unchanged.
- A write arriving while the FIFO is empty and a frame is in STOP is popped at that STOP's end if it was written at least one edge earlier.

Decomposition:
- uart.vh (shared include) holds:
  - UART_DATA_BITS (8).
  - Default CLK_FREQ and BAUD defines.
  - FSM state encodings: UART_TX_IDLE, UART_TX_START, UART_TX_DATA, UART_TX_STOP (2-bit).
- Sub-module uart_tx_fifo: synchronous FIFO, parameters WIDTH and DEPTH, with ports wr/rd/din/dout/full/empty.
  - dout is a combinational read of the head entry, so a pop and its load happen in the same cycle.
- uart_tx instantiates uart_tx_fifo and contains the FSM, baud counter and shift register.

Test Plan (CLK_FREQ=12000000, BAUD=115200, 104 cycles/bit):
- Single byte 0xA5 written at edge N -> tx_o low from N+1 for 104 cycles; then 1,0,1,0,0,1,0,1 (LSB first), 104 cycles each; then high for 104 cycles; busy_o drops at N+1041.
- Bytes 0x00, 0xFF, 0x55 written on 3 consecutive cycles -> three contiguous 1040-cycle frames; stop bit followed directly by start bit; no extra idle cycles.
- 17 writes 0x00..0x10 on consecutive cycles with tx_o held in its first frame:
  - The first byte is popped at once, so 0x00..0x10 all fit (1 in flight + 16 queued); ready_o=0 after the 17th.
  - An 18th write 0x11 -> dropped, overflow_o=1 and stays 1.
  - The line emits 0x00..0x10 in order.
- Fill to full, then write while the FSM pops in the same cycle -> write dropped, overflow_o=1, count = DEPTH-1.
- Assert rstn_i=0 mid-DATA with 3 bytes queued -> tx_o=1 immediately (async), busy_o=0, ready_o=1. After release, no stale bytes are transmitted and tx_o stays high.
- Serial loopback of tx_o into uart_rx, bytes 0x00..0xFF -> every byte received matches, with no framing errors.
